// File: rtl/sd_pkg.sv
// Shared SD definitions: response FSM states and CRC7 helper.
// crc7_next is also used by the command transmitter.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    CHECK
  } rsp_state_t;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_next(
    input logic [6:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), zero init, with synchronous clear.
import sd_pkg::*;

module sd_crc7 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_next(crc, din);
    end
  end

endmodule

// File: rtl/sipo_reg.sv
// Parameterised serial-to-parallel register, MSB-first, resets to ones.
module sipo_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= '1;
    end else if (shift_en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/sd_rsp_rx_ctrl.sv
// SD CMD-line response receiver sequencer: start detect, bit/byte
// framing, CRC7 and end-bit check, timeout.
import sd_pkg::*;

module sd_rsp_rx_ctrl #(
  parameter int RSP_BITS    = 48,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sample_en,
  input  logic       cmd_in,
  input  logic       arm,
  input  logic       crc_check_en,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rsp_done,
  output logic       crc_err,
  output logic       end_err,
  output logic       timeout
);

  localparam int CRC_LO = (RSP_BITS == 136) ? 8 : 0;
  localparam int CRC_HI = RSP_BITS - 9;
  localparam int WCW    = $clog2(TIMEOUT_CYC + 1);

  rsp_state_t     state;
  logic [7:0]     bit_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           chk_en;
  logic [6:0]     crc;
  logic           shift;
  logic           crc_en;
  logic           crc_clr;
  int             idx;

  always_comb begin
    shift = 1'b0;
    if (sample_en) begin
      shift = (state == RECEIVE) ||
              (state == WAIT_START && !cmd_in);
    end
    idx     = int'(bit_cnt);
    crc_en  = shift && (idx >= CRC_LO) && (idx <= CRC_HI);
    crc_clr = arm && (state == IDLE);
  end

  assign busy = (state != IDLE);

  sipo_reg #(.W(8)) u_shift (
    .clk      (clk),
    .n_rst    (n_rst),
    .shift_en (shift),
    .din      (cmd_in),
    .q        (rx_byte)
  );

  sd_crc7 u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (cmd_in),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      chk_en     <= 1'b0;
      byte_valid <= 1'b0;
      rsp_done   <= 1'b0;
      crc_err    <= 1'b0;
      end_err    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rsp_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arm) begin
            state    <= WAIT_START;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            chk_en   <= crc_check_en;
          end
        end
        WAIT_START: begin
          if (sample_en) begin
            if (!cmd_in) begin
              bit_cnt <= 8'd1;
              state   <= RECEIVE;
            end else if (wait_cnt == WCW'(TIMEOUT_CYC - 1)) begin
              timeout  <= 1'b1;
              rsp_done <= 1'b1;
              state    <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (sample_en) begin
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt[2:0] == 3'd7) begin
              byte_valid <= 1'b1;
            end
            if (bit_cnt == 8'(RSP_BITS - 1)) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          // last shifted byte is {received crc7, end bit}
          crc_err  <= chk_en && (rx_byte[7:1] != crc);
          end_err  <= !rx_byte[0];
          rsp_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
